dcache_miss_handler: RTL and testbench

Line-miss initiator between the data cache and the line-granular data memory port. Accepts one miss at a time from the cache, writes back the dirty victim line if required, issues the refill read, and returns the 128-bit refill line to the cache. It is the requester side of the memory's valid/ready request/response protocol: 32-bit line address, write enable, 128-bit write line, and a response carrying the line address and a 128-bit line.

---
 rtl/tartaruga_pkg.sv | 9 +
 rtl/dcache_miss_handler.sv | 143 ++++++++++++++
 tb/tb_dcache_miss_handler.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tartaruga_pkg.sv
// Shared bus and cache-line types for the tartaruga memory subsystem.
package tartaruga_pkg;

  typedef logic [31:0]  bus32_t;
  typedef logic [127:0] line_t;

  localparam int unsigned LINE_OFFSET_W = 4;

endpackage

// File: rtl/dcache_miss_handler.sv
// Data-cache line-miss initiator: optional dirty-victim writeback, then a refill
// read, then a hand-off of the refill line to the cache.
module dcache_miss_handler
  import tartaruga_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   miss_valid_i,
  output logic   miss_ready_o,
  input  bus32_t miss_addr_i,
  input  logic   miss_dirty_i,
  input  bus32_t victim_addr_i,
  input  line_t  victim_data_i,
  output logic   fill_valid_o,
  input  logic   fill_ready_i,
  output bus32_t fill_addr_o,
  output line_t  fill_data_o,
  output logic   mem_req_valid_o,
  input  logic   mem_req_ready_i,
  output bus32_t mem_addr_o,
  output logic   mem_we_o,
  output line_t  mem_data_wr_o,
  input  logic   mem_rsp_valid_i,
  output logic   mem_rsp_ready_o,
  input  bus32_t mem_rsp_addr_i,
  input  line_t  mem_data_line_i,
  output logic   busy_o,
  output logic   err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_WB_RSP,
    S_RF_REQ,
    S_RF_RSP,
    S_FILL,
    S_ERR
  } state_e;

  localparam int unsigned TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_e          state_q;
  bus32_t          miss_addr_q;
  bus32_t          victim_addr_q;
  line_t           victim_data_q;
  line_t           fill_data_q;
  logic [TW-1:0]   timer_q;

  logic            timeout_hit;
  logic            rsp_hs;
  logic            rsp_match_victim;
  logic            rsp_match_miss;
  logic            unused_addr_bits;

  // The timer value seen here is the count before this cycle's increment, so the
  // hit fires on the cycle the count would reach TIMEOUT_CYC.
  assign timeout_hit      = (TIMEOUT_CYC != 0) && (timer_q == TW'(TIMEOUT_CYC - 1));
  assign rsp_hs           = mem_rsp_valid_i && mem_rsp_ready_o;
  assign rsp_match_victim = mem_rsp_addr_i[31:LINE_OFFSET_W] == victim_addr_q[31:LINE_OFFSET_W];
  assign rsp_match_miss   = mem_rsp_addr_i[31:LINE_OFFSET_W] == miss_addr_q[31:LINE_OFFSET_W];
  assign unused_addr_bits = ^{mem_rsp_addr_i[LINE_OFFSET_W-1:0],
                              miss_addr_i[LINE_OFFSET_W-1:0],
                              victim_addr_i[LINE_OFFSET_W-1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      miss_addr_q   <= '0;
      victim_addr_q <= '0;
      victim_data_q <= '0;
      fill_data_q   <= '0;
      timer_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss_valid_i) begin
            miss_addr_q   <= {miss_addr_i[31:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
            victim_addr_q <= {victim_addr_i[31:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
            victim_data_q <= victim_data_i;
            state_q       <= miss_dirty_i ? S_WB_REQ : S_RF_REQ;
          end
        end
        S_WB_REQ: begin
          if (mem_req_ready_i) begin
            state_q <= S_WB_RSP;
            timer_q <= '0;
          end
        end
        S_WB_RSP: begin
          if (rsp_hs) begin
            state_q <= rsp_match_victim ? S_RF_REQ : S_ERR;
          end else if (timeout_hit) begin
            state_q <= S_ERR;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_RF_REQ: begin
          if (mem_req_ready_i) begin
            state_q <= S_RF_RSP;
            timer_q <= '0;
          end
        end
        S_RF_RSP: begin
          if (rsp_hs) begin
            if (rsp_match_miss) begin
              fill_data_q <= mem_data_line_i;
              state_q     <= S_FILL;
            end else begin
              state_q <= S_ERR;
            end
          end else if (timeout_hit) begin
            state_q <= S_ERR;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_FILL: begin
          if (fill_ready_i) state_q <= S_IDLE;
        end
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign miss_ready_o    = (state_q == S_IDLE);
  assign busy_o          = (state_q != S_IDLE);
  assign err_o           = (state_q == S_ERR);
  assign mem_req_valid_o = (state_q == S_WB_REQ) || (state_q == S_RF_REQ);
  assign mem_we_o        = (state_q == S_WB_REQ);
  assign mem_addr_o      = (state_q == S_WB_REQ) ? victim_addr_q :
                           (state_q == S_RF_REQ) ? miss_addr_q   : '0;
  assign mem_data_wr_o   = (state_q == S_WB_REQ) ? victim_data_q : '0;
  assign mem_rsp_ready_o = (state_q == S_WB_RSP) || (state_q == S_RF_RSP);
  assign fill_valid_o    = (state_q == S_FILL);
  assign fill_addr_o     = miss_addr_q;
  assign fill_data_o     = fill_data_q;

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Directed bench for dcache_miss_handler with a fixed-latency line memory model.
module tb_dcache_miss_handler;
  import tartaruga_pkg::*;

  localparam int unsigned LAT = 5;

  logic   clk = 1'b0;
  logic   rst_i;
  logic   miss_valid_i, miss_ready_o, miss_dirty_i;
  bus32_t miss_addr_i, victim_addr_i;
  line_t  victim_data_i;
  logic   fill_valid_o, fill_ready_i;
  bus32_t fill_addr_o;
  line_t  fill_data_o;
  logic   mem_req_valid_o, mem_req_ready_i, mem_we_o;
  bus32_t mem_addr_o;
  line_t  mem_data_wr_o;
  logic   mem_rsp_valid_i, mem_rsp_ready_o;
  bus32_t mem_rsp_addr_i;
  line_t  mem_data_line_i;
  logic   busy_o, err_o;

  // Second instance with the timeout disabled, sharing all inputs.
  logic   d1_miss_ready, d1_fill_valid, d1_req_valid, d1_we, d1_rsp_ready, d1_busy, d1_err;
  bus32_t d1_fill_addr, d1_mem_addr;
  line_t  d1_fill_data, d1_data_wr;

  logic   mem_silent;
  bus32_t addr_xor;

  int n_vec  = 0;
  int n_miss = 0;

  dcache_miss_handler #(.TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_addr_i(miss_addr_i),
    .miss_dirty_i(miss_dirty_i), .victim_addr_i(victim_addr_i), .victim_data_i(victim_data_i),
    .fill_valid_o(fill_valid_o), .fill_ready_i(fill_ready_i), .fill_addr_o(fill_addr_o),
    .fill_data_o(fill_data_o), .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_data_wr_o(mem_data_wr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_addr_i(mem_rsp_addr_i), .mem_data_line_i(mem_data_line_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  dcache_miss_handler #(.TIMEOUT_CYC(0)) dut_noto (
    .clk_i(clk), .rst_i(rst_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(d1_miss_ready), .miss_addr_i(miss_addr_i),
    .miss_dirty_i(miss_dirty_i), .victim_addr_i(victim_addr_i), .victim_data_i(victim_data_i),
    .fill_valid_o(d1_fill_valid), .fill_ready_i(fill_ready_i), .fill_addr_o(d1_fill_addr),
    .fill_data_o(d1_fill_data), .mem_req_valid_o(d1_req_valid), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(d1_mem_addr), .mem_we_o(d1_we), .mem_data_wr_o(d1_data_wr),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(d1_rsp_ready),
    .mem_rsp_addr_i(mem_rsp_addr_i), .mem_data_line_i(mem_data_line_i),
    .busy_o(d1_busy), .err_o(d1_err)
  );

  always #5 clk = ~clk;

  function automatic line_t line_of(input bus32_t a);
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, ".miss_ready"}, miss_ready_o, 1);
    check({tag, ".busy"}, busy_o, 0);
    check({tag, ".err"}, err_o, 0);
    check({tag, ".req_valid"}, mem_req_valid_o, 0);
    check({tag, ".fill_valid"}, fill_valid_o, 0);
    check({tag, ".rsp_ready"}, mem_rsp_ready_o, 0);
  endtask

  // Memory model: response valid LAT cycles after the request handshake cycle,
  // each word equal to its own byte address.
  initial begin
    bit     hs_req, hs_rsp, rst_seen, pending;
    int     cnt;
    bus32_t cap, raddr;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_addr_i  = '0;
    mem_data_line_i = '0;
    pending = 1'b0;
    cnt     = 0;
    raddr   = '0;
    forever begin
      @(posedge clk);
      hs_req   = mem_req_valid_o && mem_req_ready_i;
      hs_rsp   = mem_rsp_valid_i && mem_rsp_ready_o;
      cap      = mem_addr_o;
      rst_seen = rst_i;
      #1;
      if (rst_seen) begin
        pending         = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_addr_i  = '0;
        mem_data_line_i = '0;
      end else begin
        if (hs_rsp) mem_rsp_valid_i = 1'b0;
        if (hs_req) begin
          pending = 1'b1;
          cnt     = LAT - 1;
          raddr   = cap;
        end else if (pending && !mem_silent) begin
          cnt--;
          if (cnt == 0) begin
            pending         = 1'b0;
            mem_rsp_valid_i = 1'b1;
            mem_rsp_addr_i  = raddr ^ addr_xor;
            mem_data_line_i = line_of(raddr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    miss_valid_i = 1'b0; miss_addr_i = '0; miss_dirty_i = 1'b0;
    victim_addr_i = '0; victim_data_i = '0;
    fill_ready_i = 1'b1; mem_req_ready_i = 1'b1;
    mem_silent = 1'b0; addr_xor = '0;
    step(3);
    rst_i = 1'b0;

    check_idle("reset");
    check("reset.mem_addr", mem_addr_o, 0);
    check("reset.mem_we", mem_we_o, 0);
    check("reset.data_wr", mem_data_wr_o, 0);
    check("reset.fill_addr", fill_addr_o, 0);
    check("reset.fill_data", fill_data_o, 0);

    // Clean miss, accepted in cycle t
    step();
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_1234; miss_dirty_i = 1'b0;
    @(negedge clk);
    check("clean.accept", miss_ready_o, 1);
    step(); miss_valid_i = 1'b0;
    @(negedge clk);
    check("clean.t1.req_valid", mem_req_valid_o, 1);
    check("clean.t1.addr", mem_addr_o, 32'h1230);
    check("clean.t1.we", mem_we_o, 0);
    check("clean.t1.data_wr", mem_data_wr_o, 0);
    step(5);
    @(negedge clk);
    check("clean.t6.fill_valid", fill_valid_o, 0);
    step();
    @(negedge clk);
    check("clean.t7.fill_valid", fill_valid_o, 1);
    check("clean.t7.fill_addr", fill_addr_o, 32'h1230);
    check("clean.t7.fill_data", fill_data_o,
          {32'h0000_123C, 32'h0000_1238, 32'h0000_1234, 32'h0000_1230});
    step();
    check_idle("clean.done");

    // Dirty miss
    step();
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_3000; miss_dirty_i = 1'b1;
    victim_addr_i = 32'h0000_2040; victim_data_i = {4{32'hDEAD_BEEF}};
    step(); miss_valid_i = 1'b0; miss_dirty_i = 1'b0;
    @(negedge clk);
    check("dirty.t1.req_valid", mem_req_valid_o, 1);
    check("dirty.t1.we", mem_we_o, 1);
    check("dirty.t1.addr", mem_addr_o, 32'h2040);
    check("dirty.t1.data_wr", mem_data_wr_o, {4{32'hDEAD_BEEF}});
    step(5);
    @(negedge clk);
    check("dirty.t6.req_valid", mem_req_valid_o, 0);
    check("dirty.t6.rsp_ready", mem_rsp_ready_o, 1);
    step();
    @(negedge clk);
    check("dirty.t7.req_valid", mem_req_valid_o, 1);
    check("dirty.t7.addr", mem_addr_o, 32'h3000);
    check("dirty.t7.we", mem_we_o, 0);
    check("dirty.t7.data_wr", mem_data_wr_o, 0);
    step(5);
    @(negedge clk);
    check("dirty.t12.fill_valid", fill_valid_o, 0);
    step();
    @(negedge clk);
    check("dirty.t13.fill_valid", fill_valid_o, 1);
    check("dirty.t13.fill_data", fill_data_o, line_of(32'h3000));
    step();
    check_idle("dirty.done");

    // Request and fill backpressure
    step();
    mem_req_ready_i = 1'b0; fill_ready_i = 1'b0;
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_5678;
    step(); miss_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp.req_valid", mem_req_valid_o, 1);
      check("bp.req_addr", mem_addr_o, 32'h5670);
      check("bp.req_we", mem_we_o, 0);
      check("bp.req_data", mem_data_wr_o, 0);
      step();
    end
    mem_req_ready_i = 1'b1;
    step(6);
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_9990;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp.fill_held", fill_valid_o, 1);
      check("bp.fill_data", fill_data_o, line_of(32'h5670));
      check("bp.miss_blocked", miss_ready_o, 0);
      step();
    end
    fill_ready_i = 1'b1;
    @(negedge clk);
    check("bp.fill_hs.miss_ready", miss_ready_o, 0);
    step(); miss_valid_i = 1'b0;
    check_idle("bp.done");

    // Response address mismatch
    step();
    addr_xor = 32'h0000_0070;
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_1230;
    step(); miss_valid_i = 1'b0;
    step(5);
    @(negedge clk);
    check("mm.t6.err", err_o, 0);
    step();
    @(negedge clk);
    check("mm.t7.err", err_o, 1);
    check("mm.t7.miss_ready", miss_ready_o, 0);
    check("mm.t7.rsp_ready", mem_rsp_ready_o, 0);
    check("mm.t7.req_valid", mem_req_valid_o, 0);
    check("mm.t7.busy", busy_o, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check("mm.fill_valid", fill_valid_o, 0);
      check("mm.err_sticky", err_o, 1);
    end
    addr_xor = '0;
    do_reset();
    check_idle("mm.reset");

    // Timeout: silent memory
    step();
    mem_silent = 1'b1;
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_1230;
    step(); miss_valid_i = 1'b0;
    step(8);
    @(negedge clk);
    check("to.t9.err", err_o, 0);
    step();
    @(negedge clk);
    check("to.t10.err", err_o, 1);
    check("to.noto.err", d1_err, 0);
    step(1000);
    @(negedge clk);
    check("to.noto.err_1000", d1_err, 0);
    check("to.noto.busy_1000", d1_busy, 1);
    check("to.noto.rsp_ready", d1_rsp_ready, 1);
    mem_silent = 1'b0;
    do_reset();
    check_idle("to.reset");
    check("to.noto.reset_busy", d1_busy, 0);

    // Reset while waiting for the refill response
    step();
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_4440;
    step(); miss_valid_i = 1'b0;
    step(2);
    @(negedge clk);
    check("rst.in_rsp", mem_rsp_ready_o, 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_idle("rst.abort");
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_777C;
    step(); miss_valid_i = 1'b0;
    @(negedge clk);
    check("rst.fresh.addr", mem_addr_o, 32'h7770);
    step(6);
    @(negedge clk);
    check("rst.fresh.fill_valid", fill_valid_o, 1);
    check("rst.fresh.fill_addr", fill_addr_o, 32'h7770);
    check("rst.fresh.fill_data", fill_data_o, line_of(32'h7770));
    step();
    check_idle("rst.fresh.done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
